vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-003 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-005 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-006 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-007 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical front porch, sync and back porch in lines.
REQ-008 Parameters HS_POL, VS_POL, default 0, sync active level (0 = active-low).
REQ-009 Parameter XY_W, 12, width of x/y outputs and of internal counters.
REQ-010 Ports: clk in 1 pixel-domain clock; rst in 1 async active-high reset; pix_ce in 1 pixel clock enable; en in 1 generator enable.
REQ-011 Ports: hs out 1 hsync; vs out 1 vsync; active out 1 visible-region flag; x out XY_W column; y out XY_W row.
REQ-012 Ports: line_start out 1 one-cycle pulse; frame_start out 1 one-cycle pulse; frame_cnt out 16 frame counter; rgb out 12 test-pattern pixel.

Function
REQ-013 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise; line order is sync, back porch, active, front porch, on both axes.
REQ-014 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL advance only on h_cnt wrap and count 0..V_TOTAL-1 and wrap.
REQ-015 Counters SHALL advance only in cycles with pix_ce=1 and en=1; with pix_ce=0 every register holds.
REQ-016 All outputs SHALL be registered; outputs in cycle k reflect counter values of cycle k-1 (latency one clk).
REQ-017 hs = HS_POL while h_cnt < H_SYNC, else ~HS_POL; vs = VS_POL while v_cnt < V_SYNC, else ~VS_POL.
REQ-018 active = 1 iff h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-019 x = h_cnt-(H_SYNC+H_BP), y = v_cnt-(V_SYNC+V_BP) when active; x = y = 0 otherwise.
REQ-020 line_start SHALL pulse one clk when h_cnt=0 is presented; frame_start when h_cnt=0 and v_cnt=0 (coincident with line_start).
REQ-021 frame_cnt SHALL increment, modulo 2^16, on each frame_start; 0xFFFF wraps to 0.
REQ-022 en=0 SHALL synchronously clear counters to 0 and force outputs to reset values in the next clk; frame_cnt holds; on en re-assert, the first output cycle is frame_start.

Reset
REQ-023 rst SHALL immediately clear h_cnt, v_cnt, frame_cnt, x, y, active, line_start, frame_start, rgb to 0 and drive hs = ~HS_POL, vs = ~VS_POL.
REQ-024 Reset mid-line or mid-frame SHALL abandon the frame; after release, timing restarts at h_cnt=v_cnt=0.

Configuration
REQ-025 Macro VGA_TG_PATTERN_EN defined: rgb = 8 vertical colour bars, each H_ACTIVE/8 wide (last bar absorbs remainder), order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000, registered alongside x; rgb = 0 when active=0.
REQ-026 Macro not defined: rgb tied to 12'h000, no pattern logic synthesised.

Structure
REQ-027 Package vga_timing_pkg SHALL hold default timing constants for 640x480@60 and 800x600@60 and the colour-bar constants.
REQ-028 One sub-module vga_axis_counter (parametrised total, sync, back porch, active; outputs count, wrap, sync, in_active) SHALL be instantiated once per axis.

Verification
REQ-029 Defaults, pix_ce=1, en=1: hs low 96 clk per 800-clk line; vs low 1600 clk; frame_start period 420000 clk.
REQ-030 Defaults: active first high with x=0,y=0 at h_cnt=144, v_cnt=35; last active pixel x=639,y=479; x,y=0 in blanking.
REQ-031 pix_ce high 1 of 4 clk: line period 3200 clk, all outputs stable across ce=0 cycles.
REQ-032 rst pulsed at h_cnt=400, v_cnt=200: outputs at reset values same cycle; after release, frame_start after one clk, frame_cnt=1.
REQ-033 en low mid-frame for 10 clk: outputs idle next clk, frame_cnt held; re-assert -> frame_start next output cycle, frame_cnt+1.
REQ-034 VGA_TG_PATTERN_EN defined: x=0..79 rgb=FFF, x=80 rgb=FF0, x=639 rgb=000, blanking rgb=000; undefined: rgb always 000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60, 800x600@60) and colour-bar constants.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam logic VGA640_HS_POL = 1'b0;
    localparam logic VGA640_VS_POL = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam logic SVGA800_HS_POL = 1'b1;
    localparam logic SVGA800_VS_POL = 1'b1;

    localparam int NUM_BARS = 8;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            BAR_WHITE:   c = RGB_WHITE;
            BAR_YELLOW:  c = RGB_YELLOW;
            BAR_CYAN:    c = RGB_CYAN;
            BAR_GREEN:   c = RGB_GREEN;
            BAR_MAGENTA: c = RGB_MAGENTA;
            BAR_RED:     c = RGB_RED;
            BAR_BLUE:    c = RGB_BLUE;
            default:     c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 laid out as sync, back porch, active, front porch.
module vga_axis_counter #(
    parameter int TOTAL  = 800,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int W      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         in_active
);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_END = W'(SYNC);
    localparam logic [W-1:0] ACT_LO   = W'(SYNC + BP);
    localparam logic [W-1:0] ACT_HI   = W'(SYNC + BP + ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (adv) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    assign wrap      = (count == LAST);
    assign sync      = (count < SYNC_END);
    assign in_active = (count >= ACT_LO) && (count < ACT_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator with registered outputs; define VGA_TG_PATTERN_EN
// to add an 8-bar colour test pattern on rgb (otherwise rgb is constant 0).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic HS_POL   = VGA640_HS_POL,
    parameter logic VS_POL   = VGA640_VS_POL,
    parameter int   XY_W     = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_ce,
    input  logic            en,
    output logic            hs,
    output logic            vs,
    output logic            active,
    output logic [XY_W-1:0] x,
    output logic [XY_W-1:0] y,
    output logic            line_start,
    output logic            frame_start,
    output logic [15:0]     frame_cnt,
    output logic [11:0]     rgb
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [XY_W-1:0] H_ORG = XY_W'(H_SYNC + H_BP);
    localparam logic [XY_W-1:0] V_ORG = XY_W'(V_SYNC + V_BP);

    logic            run;
    logic [XY_W-1:0] h_cnt, v_cnt;
    logic            h_wrap, v_wrap;
    logic            h_sync, v_sync;
    logic            h_act, v_act;

    // en low parks both counters at the frame origin so the next run starts a frame
    assign run = en & pix_ce;

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .W      (XY_W)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .clr       (~en),
        .adv       (run),
        .count     (h_cnt),
        .wrap      (h_wrap),
        .sync      (h_sync),
        .in_active (h_act)
    );

    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .W      (XY_W)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .clr       (~en),
        .adv       (run & h_wrap),
        .count     (v_cnt),
        .wrap      (v_wrap),
        .sync      (v_sync),
        .in_active (v_act)
    );

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

    // Stage 0: decode current counter position
    logic            active_nxt;
    logic            line_nxt;
    logic            frame_nxt;
    logic [XY_W-1:0] x_nxt, y_nxt;

    assign active_nxt = h_act & v_act;
    assign line_nxt   = (h_cnt == '0);
    assign frame_nxt  = line_nxt && (v_cnt == '0);
    assign x_nxt      = active_nxt ? (h_cnt - H_ORG) : '0;
    assign y_nxt      = active_nxt ? (v_cnt - V_ORG) : '0;

    // Stage 1: registered outputs, one clk behind the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            hs          <= h_sync ? HS_POL : ~HS_POL;
            vs          <= v_sync ? VS_POL : ~VS_POL;
            active      <= active_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
        end
    end

    // frame_cnt survives en=0 and wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (run && frame_nxt) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef VGA_TG_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / NUM_BARS > 0) ? (H_ACTIVE / NUM_BARS) : 1;

    logic [XY_W-1:0] bar_q;
    logic [2:0]      bar_idx;
    logic [11:0]     rgb_nxt;

    // The last bar swallows any remainder columns of H_ACTIVE
    assign bar_q   = x_nxt / XY_W'(BAR_W);
    assign bar_idx = (bar_q > XY_W'(NUM_BARS - 1)) ? 3'd7 : bar_q[2:0];
    assign rgb_nxt = active_nxt ? bar_rgb(bar_idx) : RGB_BLACK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else if (!en) begin
            rgb <= '0;
        end else if (pix_ce) begin
            rgb <= rgb_nxt;
        end
    end
`else
    assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default horizontal timing, shortened vertical timing (10 lines/frame).
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b1;
    logic        en = 1'b1;
    logic        hs, vs, active, line_start, frame_start;
    logic [11:0] x, y, rgb;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .en          (en),
        .hs          (hs),
        .vs          (vs),
        .active      (active),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .rgb         (rgb)
    );

    function automatic logic [56:0] snap();
        return {hs, vs, active, x, y, line_start, frame_start, frame_cnt, rgb};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; pix_ce = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (hs !== 1'b1) begin errors++; $display("FAIL rst_hs got %b want 1", hs); end
        checks++; if (vs !== 1'b1) begin errors++; $display("FAIL rst_vs got %b want 1", vs); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", active); end
        checks++; if (x !== 12'd0 || y !== 12'd0) begin errors++; $display("FAIL rst_xy got %0d,%0d want 0,0", x, y); end
        checks++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b want 00", line_start, frame_start); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rst_rgb got %h want 000", rgb); end
    endtask

    task automatic test_frame_start();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b want 1", frame_start); end
        checks++; if (line_start !== 1'b1) begin errors++; $display("FAIL first_line_start got %b want 1", line_start); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL first_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (hs !== 1'b0 || vs !== 1'b0) begin errors++; $display("FAIL first_sync got hs=%b vs=%b want 0 0", hs, vs); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL first_active got %b want 0", active); end
    endtask

    // Positions 0..799 of line 0 (position 0 already presented)
    task automatic test_hsync();
        int hs_low, ls_n, last_low;
        hs_low = (hs == 1'b0) ? 1 : 0;
        ls_n = line_start ? 1 : 0;
        last_low = 0;
        for (int p = 1; p < 800; p++) begin
            @(negedge clk);
            if (hs == 1'b0) begin hs_low++; last_low = p; end
            if (line_start) ls_n++;
        end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL hs_low_per_line got %0d want 96", hs_low); end
        checks++; if (last_low != 95) begin errors++; $display("FAIL hs_last_low_pos got %0d want 95", last_low); end
        checks++; if (ls_n != 1) begin errors++; $display("FAIL line_start_per_line got %0d want 1", ls_n); end
    endtask

    // Positions 800..8799: one full frame window crossing into frame 2
    task automatic test_frame();
        int vs_low, fs_n, fs_pos, act_n, first_pos, last_pos, blank_bad, rgb_bad;
        logic [11:0] first_x, first_y, last_x, last_y;
        logic [11:0] rgb0, rgb79, rgb80, rgb320, rgb639;
        vs_low = 0; fs_n = 0; fs_pos = -1; act_n = 0; first_pos = -1; last_pos = -1;
        blank_bad = 0; rgb_bad = 0;
        first_x = 'x; first_y = 'x; last_x = 'x; last_y = 'x;
        rgb0 = 'x; rgb79 = 'x; rgb80 = 'x; rgb320 = 'x; rgb639 = 'x;
        for (int p = 800; p < 8800; p++) begin
            @(negedge clk);
            if (vs == 1'b0) vs_low++;
            if (frame_start) begin fs_n++; fs_pos = p; end
            if (active) begin
                act_n++;
                if (first_pos < 0) begin first_pos = p; first_x = x; first_y = y; end
                last_pos = p; last_x = x; last_y = y;
                if (y == 12'd0) begin
                    if (x == 12'd0)   rgb0 = rgb;
                    if (x == 12'd79)  rgb79 = rgb;
                    if (x == 12'd80)  rgb80 = rgb;
                    if (x == 12'd320) rgb320 = rgb;
                    if (x == 12'd639) rgb639 = rgb;
                end
            end else begin
                if (x != 12'd0 || y != 12'd0) blank_bad++;
                if (rgb != 12'h000) rgb_bad++;
            end
        end
        checks++; if (vs_low != 1600) begin errors++; $display("FAIL vs_low_clk got %0d want 1600", vs_low); end
        checks++; if (fs_n != 1 || fs_pos != 8000) begin errors++; $display("FAIL frame_period got n=%0d pos=%0d want n=1 pos=8000", fs_n, fs_pos); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL frame_cnt_2nd got %0d want 2", frame_cnt); end
        checks++; if (act_n != 2560) begin errors++; $display("FAIL active_count got %0d want 2560", act_n); end
        checks++; if (first_pos != 4144 || first_x !== 12'd0 || first_y !== 12'd0) begin errors++; $display("FAIL first_active got pos=%0d x=%0d y=%0d want 4144 0 0", first_pos, first_x, first_y); end
        checks++; if (last_pos != 7183 || last_x !== 12'd639 || last_y !== 12'd3) begin errors++; $display("FAIL last_active got pos=%0d x=%0d y=%0d want 7183 639 3", last_pos, last_x, last_y); end
        checks++; if (blank_bad != 0) begin errors++; $display("FAIL blank_xy got %0d nonzero want 0", blank_bad); end
        checks++; if (rgb_bad != 0) begin errors++; $display("FAIL blank_rgb got %0d nonzero want 0", rgb_bad); end
`ifdef VGA_TG_PATTERN_EN
        checks++; if (rgb0 !== 12'hFFF) begin errors++; $display("FAIL rgb_x0 got %h want FFF", rgb0); end
        checks++; if (rgb79 !== 12'hFFF) begin errors++; $display("FAIL rgb_x79 got %h want FFF", rgb79); end
        checks++; if (rgb80 !== 12'hFF0) begin errors++; $display("FAIL rgb_x80 got %h want FF0", rgb80); end
        checks++; if (rgb320 !== 12'hF0F) begin errors++; $display("FAIL rgb_x320 got %h want F0F", rgb320); end
        checks++; if (rgb639 !== 12'h000) begin errors++; $display("FAIL rgb_x639 got %h want 000", rgb639); end
`else
        checks++; if (rgb0 !== 12'h000 || rgb79 !== 12'h000 || rgb80 !== 12'h000) begin errors++; $display("FAIL rgb_off_left got %h %h %h want 000", rgb0, rgb79, rgb80); end
        checks++; if (rgb320 !== 12'h000 || rgb639 !== 12'h000) begin errors++; $display("FAIL rgb_off_right got %h %h want 000", rgb320, rgb639); end
`endif
    endtask

    // Reset at h=400, v=6 of frame 2 (position 13200 counted from the first frame)
    task automatic test_reset_mid();
        repeat (13200 - 8799) @(negedge clk);
        checks++; if (active !== 1'b1 || x !== 12'd256 || y !== 12'd1) begin errors++; $display("FAIL pre_rst_pos got a=%b x=%0d y=%0d want 1 256 1", active, x, y); end
        #2 rst = 1'b1;
        #1;
        checks++; if (active !== 1'b0 || x !== 12'd0 || y !== 12'd0) begin errors++; $display("FAIL async_rst_xy got a=%b x=%0d y=%0d want 0 0 0", active, x, y); end
        checks++; if (hs !== 1'b1 || vs !== 1'b1) begin errors++; $display("FAIL async_rst_sync got hs=%b vs=%b want 1 1", hs, vs); end
        checks++; if (frame_cnt !== 16'd0 || rgb !== 12'h000) begin errors++; $display("FAIL async_rst_cnt got fc=%0d rgb=%h want 0 000", frame_cnt, rgb); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1 || line_start !== 1'b1) begin errors++; $display("FAIL post_rst_start got fs=%b ls=%b want 1 1", frame_start, line_start); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_en_gap();
        repeat (5000) @(negedge clk);
        checks++; if (active !== 1'b1 || x !== 12'd56 || y !== 12'd1) begin errors++; $display("FAIL pre_en_pos got a=%b x=%0d y=%0d want 1 56 1", active, x, y); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (active !== 1'b0 || x !== 12'd0 || y !== 12'd0) begin errors++; $display("FAIL en_off_xy got a=%b x=%0d y=%0d want 0 0 0", active, x, y); end
        checks++; if (hs !== 1'b1 || vs !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL en_off_ctrl got %b%b%b%b want 1100", hs, vs, line_start, frame_start); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL en_off_frame_cnt got %0d want 1", frame_cnt); end
        repeat (9) @(negedge clk);
        checks++; if (active !== 1'b0 || frame_cnt !== 16'd1 || hs !== 1'b1) begin errors++; $display("FAIL en_hold got a=%b fc=%0d hs=%b want 0 1 1", active, frame_cnt, hs); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1 || line_start !== 1'b1) begin errors++; $display("FAIL en_on_start got fs=%b ls=%b want 1 1", frame_start, line_start); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL en_on_frame_cnt got %0d want 2", frame_cnt); end
        checks++; if (hs !== 1'b0 || vs !== 1'b0) begin errors++; $display("FAIL en_on_sync got hs=%b vs=%b want 0 0", hs, vs); end
    endtask

    // pix_ce high one clk in four; line_start rises must be 3200 clk apart
    task automatic test_pix_ce();
        logic [56:0] prev, cur;
        logic prev_ls;
        int rises, rise0, rise1, unstable;
        rises = 0; rise0 = -1; rise1 = -1; unstable = 0;
        prev = snap();
        prev_ls = line_start;
        for (int i = 0; i < 7000; i++) begin
            pix_ce = (i % 4 == 0);
            @(negedge clk);
            cur = snap();
            if ((i % 4 != 0) && cur !== prev) unstable++;
            if (!prev_ls && line_start) begin
                if (rises == 0) rise0 = i; else if (rises == 1) rise1 = i;
                rises++;
            end
            prev = cur;
            prev_ls = line_start;
        end
        pix_ce = 1'b1;
        checks++; if (rises != 2 || rise0 != 3196) begin errors++; $display("FAIL ce_line_rises got n=%0d first=%0d want 2 3196", rises, rise0); end
        checks++; if (rise1 - rise0 != 3200) begin errors++; $display("FAIL ce_line_period got %0d want 3200", rise1 - rise0); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL ce_hold got %0d changed cycles want 0", unstable); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_start();
        test_hsync();
        test_frame();
        test_reset_mid();
        test_en_gap();
        test_pix_ce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
